// File: rtl/tr_sequencer.sv
// tr_sequencer: T/R sequencer between the SPI register block and the RF
// datapath (NCO enable, PIN band select, T/R switch). Walks the
// band-settle, T/R-settle and NCO-drain intervals so RF is never driven
// into an unsettled or receive-path network.
// Optional feature macro: TR_WATCHDOG_EN (bounds TX_ACTIVE duration).
module tr_sequencer #(
  parameter int unsigned BAND_SETTLE = 32'd2400,
  parameter int unsigned TR_SETTLE   = 32'd240,
  parameter int unsigned DRAIN       = 32'd120,
  parameter logic [31:0] WDOG_CYCLES = 32'd2_400_000_000
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        txRequest,
  input  logic [7:0]  bandReq,
  input  logic [31:0] freqReq,
  input  logic        freqLoad,
  output logic [31:0] freqControl,
  output logic        ncoEnable,
  output logic        txEnable,
  output logic [7:0]  bandSelect,
  output logic        bandErr,
  output logic        wdogTrip,
  output logic [2:0]  seqState
);

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    BAND_SET  = 3'd1,
    TR_ON     = 3'd2,
    TX_ACTIVE = 3'd3,
    NCO_OFF   = 3'd4,
    TR_OFF    = 3'd5
  } state_e;

  // True when exactly one bit of the band request is set.
  function automatic logic is_onehot(input logic [7:0] v);
    logic [7:0] vm1;
    vm1 = v - 8'd1;
    return (v != 8'd0) && ((v & vm1) == 8'd0);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] freq_q, freq_d;
  logic [7:0]  band_q, band_d;
  logic        nco_q, nco_d;
  logic        tx_q, tx_d;
  logic        band_err_q, band_err_d;
  logic [2:0]  seq_q, seq_d;
  logic        timeout_s;
  logic        wdog_expire_s;
  logic        wdog_block_s;

  // A timed state ends on the cycle its counter reads 1; <=1 also
  // releases a state whose counter was somehow left at 0.
  assign timeout_s = (cnt_q <= 32'd1);

`ifdef TR_WATCHDOG_EN
  logic [31:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_trip_q, wdog_trip_d;

  // Expire on the last allowed TX_ACTIVE cycle so TX_ACTIVE lasts WDOG_CYCLES.
  assign wdog_expire_s = (state_q == TX_ACTIVE) && (wdog_cnt_q >= (WDOG_CYCLES - 32'd1));
  assign wdog_block_s  = wdog_trip_q;
  assign wdogTrip      = wdog_trip_q;

  // Watchdog counter and sticky trip flag next-state.
  always_comb begin
    wdog_cnt_d  = 32'd0;
    wdog_trip_d = wdog_trip_q;
    if ((state_q == TX_ACTIVE) && (state_d == TX_ACTIVE)) begin
      wdog_cnt_d = wdog_cnt_q + 32'd1;
    end else begin
      wdog_cnt_d = 32'd0;
    end
    if (wdog_expire_s) begin
      wdog_trip_d = 1'b1;
    end else if ((state_q == RX_IDLE) && !txRequest) begin
      wdog_trip_d = 1'b0;
    end else begin
      wdog_trip_d = wdog_trip_q;
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wdog_cnt_q  <= 32'd0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end
`else
  logic unused_wdog_s;
  // Watchdog compiled out: TX_ACTIVE is unbounded and the limit is unused.
  assign unused_wdog_s = ^WDOG_CYCLES;
  assign wdog_expire_s = 1'b0;
  assign wdog_block_s  = 1'b0;
  assign wdogTrip      = 1'b0;
`endif

  // Next-state, interval counter and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = 32'd0;
    freq_d     = freq_q;
    band_d     = band_q;
    nco_d      = 1'b0;
    tx_d       = 1'b0;
    band_err_d = 1'b0;
    seq_d      = 3'd0;

    case (state_q)
      RX_IDLE: begin
        if (txRequest && is_onehot(bandReq) && !wdog_block_s) state_d = BAND_SET;
        else                                                   state_d = RX_IDLE;
      end
      BAND_SET: begin
        if (!txRequest)     state_d = RX_IDLE;
        else if (timeout_s) state_d = TR_ON;
        else                state_d = BAND_SET;
      end
      TR_ON: begin
        if (!txRequest)     state_d = TR_OFF;
        else if (timeout_s) state_d = TX_ACTIVE;
        else                state_d = TR_ON;
      end
      TX_ACTIVE: begin
        if (!txRequest || wdog_expire_s) state_d = NCO_OFF;
        else                             state_d = TX_ACTIVE;
      end
      NCO_OFF: begin
        if (timeout_s) state_d = TR_OFF;
        else           state_d = NCO_OFF;
      end
      TR_OFF: begin
        if (timeout_s) state_d = RX_IDLE;
        else           state_d = TR_OFF;
      end
      default: state_d = TR_OFF;
    endcase

    // Load the interval on state entry, otherwise count down toward 1.
    if (state_d != state_q) begin
      case (state_d)
        BAND_SET: cnt_d = 32'(BAND_SETTLE);
        TR_ON:    cnt_d = 32'(TR_SETTLE);
        NCO_OFF:  cnt_d = 32'(DRAIN);
        TR_OFF:   cnt_d = 32'(TR_SETTLE);
        default:  cnt_d = 32'd0;
      endcase
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end else begin
      cnt_d = 32'd0;
    end

    // Band drive tracks the request only while idle; frozen otherwise.
    if (state_q == RX_IDLE) begin
      band_d     = bandReq;
      band_err_d = txRequest && !is_onehot(bandReq);
    end else begin
      band_d     = band_q;
      band_err_d = 1'b0;
    end

    if (freqLoad) freq_d = freqReq;
    else          freq_d = freq_q;

    // Decode from the next state so outputs flip on the same edge as the state.
    case (state_d)
      TR_ON:     begin tx_d = 1'b1; nco_d = 1'b0; end
      TX_ACTIVE: begin tx_d = 1'b1; nco_d = 1'b1; end
      NCO_OFF:   begin tx_d = 1'b1; nco_d = 1'b0; end
      default:   begin tx_d = 1'b0; nco_d = 1'b0; end
    endcase
    seq_d = state_d;
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= RX_IDLE;
      cnt_q      <= 32'd0;
      freq_q     <= 32'd0;
      band_q     <= 8'd0;
      nco_q      <= 1'b0;
      tx_q       <= 1'b0;
      band_err_q <= 1'b0;
      seq_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      freq_q     <= freq_d;
      band_q     <= band_d;
      nco_q      <= nco_d;
      tx_q       <= tx_d;
      band_err_q <= band_err_d;
      seq_q      <= seq_d;
    end
  end

  assign freqControl = freq_q;
  assign ncoEnable   = nco_q;
  assign txEnable    = tx_q;
  assign bandSelect  = band_q;
  assign bandErr     = band_err_q;
  assign seqState    = seq_q;

endmodule

// File: tb/tb_tr_sequencer.sv
// Directed testbench for tr_sequencer (BAND_SETTLE=8, TR_SETTLE=4, DRAIN=3,
// WDOG_CYCLES=20). Edge e is the e-th rising edge after a scenario starts;
// inputs "at edge e" are driven just after that edge.
module tb_tr_sequencer;

  logic        clk;
  logic        rstN;
  logic        txRequest;
  logic [7:0]  bandReq;
  logic [31:0] freqReq;
  logic        freqLoad;
  logic [31:0] freqControl;
  logic        ncoEnable;
  logic        txEnable;
  logic [7:0]  bandSelect;
  logic        bandErr;
  logic        wdogTrip;
  logic [2:0]  seqState;

  int n_cmp;
  int n_fail;

`ifdef TR_WATCHDOG_EN
  localparam int KD = 30;
`else
  localparam int KD = 40;
`endif

  tr_sequencer #(
    .BAND_SETTLE(8),
    .TR_SETTLE(4),
    .DRAIN(3),
    .WDOG_CYCLES(32'd20)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .txRequest(txRequest),
    .bandReq(bandReq),
    .freqReq(freqReq),
    .freqLoad(freqLoad),
    .freqControl(freqControl),
    .ncoEnable(ncoEnable),
    .txEnable(txEnable),
    .bandSelect(bandSelect),
    .bandErr(bandErr),
    .wdogTrip(wdogTrip),
    .seqState(seqState)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    n_cmp++;
    if ({freqControl, ncoEnable, txEnable, bandSelect, bandErr, wdogTrip, seqState} !== 53'd0) begin
      n_fail++;
      $display("FAIL reset_in: outputs=%h expected 0", {freqControl, ncoEnable, txEnable, bandSelect, bandErr, wdogTrip, seqState});
    end
    #7 rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (seqState !== 3'd0 || txEnable !== 1'b0 || ncoEnable !== 1'b0 || bandErr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: seq=%0d tx=%b nco=%b err=%b expected 0", seqState, txEnable, ncoEnable, bandErr);
    end
  endtask

  task automatic test_key_up_down;
    logic [2:0] es;
    bandReq = 8'h04;
    for (int e = 0; e <= KD + 10; e++) begin
      @(posedge clk);
      #1;
      if (e == 0)       es = 3'd0;
      else if (e <= 8)  es = 3'd1;
      else if (e <= 12) es = 3'd2;
      else if (e <= KD) es = 3'd3;
      else if (e <= KD + 3) es = 3'd4;
      else if (e <= KD + 7) es = 3'd5;
      else              es = 3'd0;
      n_cmp++;
      if (seqState !== es) begin
        n_fail++;
        $display("FAIL key_state e=%0d got=%0d exp=%0d", e, seqState, es);
      end
      n_cmp++;
      if (txEnable !== (e >= 9 && e <= KD + 3)) begin
        n_fail++;
        $display("FAIL key_tx e=%0d got=%b exp=%b", e, txEnable, (e >= 9 && e <= KD + 3));
      end
      n_cmp++;
      if (ncoEnable !== (e >= 13 && e <= KD)) begin
        n_fail++;
        $display("FAIL key_nco e=%0d got=%b exp=%b", e, ncoEnable, (e >= 13 && e <= KD));
      end
      n_cmp++;
      if (bandSelect !== 8'h04 || wdogTrip !== 1'b0) begin
        n_fail++;
        $display("FAIL key_band e=%0d band=%h wdog=%b exp band=04 wdog=0", e, bandSelect, wdogTrip);
      end
      if (e == 0)  txRequest = 1'b1;
      if (e == KD) txRequest = 1'b0;
    end
  endtask

  task automatic test_abort;
    logic [2:0] es;
    bandReq = 8'h10;
    for (int e = 0; e <= 18; e++) begin
      @(posedge clk);
      #1;
      if (e == 0)       es = 3'd0;
      else if (e <= 8)  es = 3'd1;
      else if (e <= 11) es = 3'd2;
      else if (e <= 15) es = 3'd5;
      else              es = 3'd0;
      n_cmp++;
      if (seqState !== es || txEnable !== (e >= 9 && e <= 11) || ncoEnable !== 1'b0) begin
        n_fail++;
        $display("FAIL abort e=%0d seq=%0d tx=%b nco=%b exp seq=%0d tx=%b nco=0",
                 e, seqState, txEnable, ncoEnable, es, (e >= 9 && e <= 11));
      end
      if (e == 0)  txRequest = 1'b1;
      if (e == 11) txRequest = 1'b0;
    end
  endtask

  task automatic test_bad_band;
    bandReq = 8'h06;
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e >= 1 && e <= 5) begin
        n_cmp++;
        if (bandErr !== 1'b1 || seqState !== 3'd0 || txEnable !== 1'b0 || bandSelect !== 8'h06) begin
          n_fail++;
          $display("FAIL bad_band e=%0d err=%b seq=%0d tx=%b band=%h exp err=1 seq=0 tx=0 band=06",
                   e, bandErr, seqState, txEnable, bandSelect);
        end
      end
      if (e == 6) begin
        n_cmp++;
        if (bandErr !== 1'b0 || seqState !== 3'd1 || bandSelect !== 8'h02) begin
          n_fail++;
          $display("FAIL band_fixed err=%b seq=%0d band=%h exp err=0 seq=1 band=02", bandErr, seqState, bandSelect);
        end
      end
      if (e >= 7) begin
        n_cmp++;
        if (seqState !== 3'd0 || bandErr !== 1'b0) begin
          n_fail++;
          $display("FAIL band_drop e=%0d seq=%0d err=%b exp seq=0 err=0", e, seqState, bandErr);
        end
      end
      if (e == 0) txRequest = 1'b1;
      if (e == 5) bandReq = 8'h02;
      if (e == 6) txRequest = 1'b0;
    end
  endtask

  task automatic test_frozen_band_freq;
    bandReq = 8'h08;
    for (int e = 0; e <= 29; e++) begin
      @(posedge clk);
      #1;
      if (e == 17) begin
        n_cmp++;
        if (freqControl !== 32'd0) begin
          n_fail++;
          $display("FAIL freq_pre got=%h exp=00000000", freqControl);
        end
      end
      if (e >= 16 && e <= 28) begin
        n_cmp++;
        if (bandSelect !== 8'h08) begin
          n_fail++;
          $display("FAIL band_frozen e=%0d got=%h exp=08", e, bandSelect);
        end
      end
      if (e == 18 || e == 19) begin
        n_cmp++;
        if (freqControl !== 32'h1234_5678 || ncoEnable !== 1'b1) begin
          n_fail++;
          $display("FAIL freq_load e=%0d freq=%h nco=%b exp freq=12345678 nco=1", e, freqControl, ncoEnable);
        end
      end
      if (e == 28) begin
        n_cmp++;
        if (seqState !== 3'd0) begin
          n_fail++;
          $display("FAIL frozen_idle got=%0d exp=0", seqState);
        end
      end
      if (e == 29) begin
        n_cmp++;
        if (bandSelect !== 8'h40) begin
          n_fail++;
          $display("FAIL band_follow got=%h exp=40", bandSelect);
        end
      end
      if (e == 0)  txRequest = 1'b1;
      if (e == 15) bandReq = 8'h40;
      if (e == 17) begin freqReq = 32'h1234_5678; freqLoad = 1'b1; end
      if (e == 18) begin freqReq = 32'hdead_beef; freqLoad = 1'b0; end
      if (e == 20) txRequest = 1'b0;
    end
  endtask

`ifdef TR_WATCHDOG_EN
  task automatic test_watchdog;
    bandReq = 8'h04;
    for (int e = 0; e <= 52; e++) begin
      @(posedge clk);
      #1;
      if (e == 32) begin
        n_cmp++;
        if (ncoEnable !== 1'b1 || wdogTrip !== 1'b0) begin
          n_fail++;
          $display("FAIL wdog_before nco=%b trip=%b exp nco=1 trip=0", ncoEnable, wdogTrip);
        end
      end
      if (e == 33) begin
        n_cmp++;
        if (ncoEnable !== 1'b0 || wdogTrip !== 1'b1 || seqState !== 3'd4) begin
          n_fail++;
          $display("FAIL wdog_trip nco=%b trip=%b seq=%0d exp nco=0 trip=1 seq=4", ncoEnable, wdogTrip, seqState);
        end
      end
      if (e >= 41 && e <= 50) begin
        n_cmp++;
        if (seqState !== 3'd0 || txEnable !== 1'b0 || wdogTrip !== 1'b1) begin
          n_fail++;
          $display("FAIL wdog_block e=%0d seq=%0d tx=%b trip=%b exp seq=0 tx=0 trip=1", e, seqState, txEnable, wdogTrip);
        end
      end
      if (e >= 51) begin
        n_cmp++;
        if (wdogTrip !== 1'b0 || seqState !== 3'd0) begin
          n_fail++;
          $display("FAIL wdog_clear e=%0d trip=%b seq=%0d exp trip=0 seq=0", e, wdogTrip, seqState);
        end
      end
      if (e == 0)  txRequest = 1'b1;
      if (e == 50) txRequest = 1'b0;
    end
  endtask
`endif

  task automatic test_reset_mid_tx;
    bandReq = 8'h01;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 0)  txRequest = 1'b1;
      if (e == 15) begin freqReq = 32'h0bad_f00d; freqLoad = 1'b1; end
      if (e == 16) freqLoad = 1'b0;
    end
    n_cmp++;
    if (ncoEnable !== 1'b1 || txEnable !== 1'b1 || freqControl !== 32'h0bad_f00d) begin
      n_fail++;
      $display("FAIL mid_tx_pre nco=%b tx=%b freq=%h exp nco=1 tx=1 freq=0badf00d", ncoEnable, txEnable, freqControl);
    end
    #2;
    rstN = 1'b0;
    txRequest = 1'b0;
    #1;
    n_cmp++;
    if ({freqControl, ncoEnable, txEnable, bandSelect, bandErr, wdogTrip, seqState} !== 53'd0) begin
      n_fail++;
      $display("FAIL mid_tx_reset outputs=%h expected 0", {freqControl, ncoEnable, txEnable, bandSelect, bandErr, wdogTrip, seqState});
    end
    #3 rstN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (seqState !== 3'd0 || txEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset seq=%0d tx=%b exp seq=0 tx=0", seqState, txEnable);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rstN      = 1'b0;
    txRequest = 1'b0;
    bandReq   = 8'h00;
    freqReq   = 32'd0;
    freqLoad  = 1'b0;
    #15;
    test_reset();
    test_key_up_down();
    test_abort();
    test_bad_band();
    test_frozen_band_freq();
`ifdef TR_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tr_sequencer.md
# tr_sequencer

Transmit/receive sequencer between the SPI register block and the RF datapath: NCO, PIN-diode band select and T/R switch. It owns `ncoEnable`, `txEnable`, `bandSelect` and `freqControl`. It steps through band settle, T/R switch settle and NCO drain intervals so that RF is never driven into an unsettled or receive-path network. The block runs in the 240 MHz `sysClk` domain, and all request inputs are synchronous to it.

## Interface
- `BAND_SETTLE`, default 2400: cycles bandSelect is held before txEnable asserts (10 µs); must be ≥1.
- `TR_SETTLE`, default 240: cycles after a txEnable edge before the next step (1 µs); must be ≥1.
- `DRAIN`, default 120: cycles after ncoEnable drops before txEnable drops; must be ≥1.
- `WDOG_CYCLES`, default 32'd2_400_000_000: maximum TX_ACTIVE duration (10 s); used only under TR_WATCHDOG_EN.
- `clk`, input, 1: system clock, 240 MHz.
- `rstN`, input, 1: asynchronous, active-low reset.
- `txRequest`, input, 1: level; high requests transmit.
- `bandReq`, input, 8: requested band, must be one-hot.
- `freqReq`, input, 32: new NCO frequency word.
- `freqLoad`, input, 1: single-cycle strobe that loads freqReq.
- `freqControl`, output, 32: registered frequency word to the NCO.
- `ncoEnable`, output, 1: NCO run enable.
- `txEnable`, output, 1: T/R PIN switch, high = TX.
- `bandSelect`, output, 8: band filter PIN drive.
- `bandErr`, output, 1: TX refused because bandReq is not one-hot.
- `wdogTrip`, output, 1: watchdog forced TX off; tied 0 without the macro.
- `seqState`, output, 3: current state encoding, for status readback.

## Operation
- States and encodings: RX_IDLE=0, BAND_SET=1, TR_ON=2, TX_ACTIVE=3, NCO_OFF=4, TR_OFF=5. Codes 6–7 are illegal and recover to TR_OFF.
- Timed states load a down-counter with their parameter on entry. The state exits when the counter reaches 1, so each timed state lasts exactly N cycles.
- RX_IDLE:
  - bandSelect <= bandReq every cycle.
  - If txRequest && onehot(bandReq), latch bandReq into bandSelect and go to BAND_SET.
  - If txRequest && !onehot, stay in RX_IDLE with bandErr=1. bandErr clears the cycle after txRequest=0 or bandReq becomes one-hot.
- BAND_SET: bandSelect is frozen. Timeout goes to TR_ON. txRequest=0 goes to RX_IDLE immediately.
- TR_ON: txEnable=1. Timeout goes to TX_ACTIVE. txRequest=0 goes to TR_OFF.
- TX_ACTIVE: ncoEnable=1. txRequest=0 goes to NCO_OFF.
- NCO_OFF: ncoEnable=0, txEnable=1. The state runs to completion regardless of txRequest, then goes to TR_OFF.
- TR_OFF: txEnable=0. The state runs to completion, then goes to RX_IDLE. bandSelect stays frozen until RX_IDLE.
- If txRequest is still high on return to RX_IDLE, a new TX sequence starts the next cycle. There is no back-to-back shortcut.
- bandReq changes while outside RX_IDLE are ignored.
- freqLoad is accepted in every state: freqControl <= freqReq on the next edge. If freqLoad and reset coincide, reset wins.
- Outputs are registered and decoded from the state register. No combinational path runs from input to output.

## Timing
- Reset values: state RX_IDLE, freqControl=0, ncoEnable=0, txEnable=0, bandSelect=0, bandErr=0, wdogTrip=0, seqState=0, counters 0.
- Reset asserted mid-TX drops ncoEnable and txEnable asynchronously. This is accepted as safe: the PA is off.
- Key-up latency: txRequest sampled high at edge 0 → BAND_SET from edge 1 → txEnable=1 at edge 1+BAND_SETTLE → ncoEnable=1 at edge 1+BAND_SETTLE+TR_SETTLE.
- Key-down latency: txRequest sampled low at edge t → ncoEnable=0 at t+1 → txEnable=0 at t+1+DRAIN → RX_IDLE at t+1+DRAIN+TR_SETTLE.
- Invariant: ncoEnable=1 implies txEnable=1 and state==TX_ACTIVE, in every cycle.

## Configuration
- `TR_WATCHDOG_EN` defined:
  - A 32-bit up-counter runs in TX_ACTIVE. When it reaches WDOG_CYCLES, the block forces NCO_OFF and sets wdogTrip.
  - wdogTrip is sticky and blocks new TX while set.
  - wdogTrip clears in RX_IDLE the first cycle txRequest=0.
  - The counter zeroes on leaving TX_ACTIVE.
- `TR_WATCHDOG_EN` undefined: there is no counter, wdogTrip is tied 0, and TX_ACTIVE is unbounded.

## Test plan
All scenarios use BAND_SETTLE=8, TR_SETTLE=4, DRAIN=3 and WDOG_CYCLES=20.
- Key-up and key-down: bandReq=8'h04, txRequest high at edge 0.
  - Key-up: txEnable rises at edge 9, ncoEnable rises at edge 13, bandSelect=8'h04 throughout.
  - Key-down: txRequest low at edge 40. ncoEnable falls at 41, txEnable falls at 44, seqState=0 at 48.
- Abort during settle: txRequest high at edge 0, low at edge 11 (TR_ON). ncoEnable never asserts; txEnable falls at 12; RX_IDLE at 16.
- Bad band: bandReq=8'h06 with txRequest high. bandErr=1 from the next cycle, state stays 0, txEnable stays 0. Change bandReq to 8'h02: bandErr clears and BAND_SET is entered.
- Frozen band and live frequency during TX:
  - Changing bandReq during TX_ACTIVE leaves bandSelect unchanged.
  - freqLoad with freqReq=32'h1234_5678 in TX_ACTIVE → freqControl=32'h1234_5678 one edge later, with ncoEnable held.
- Watchdog (TR_WATCHDOG_EN only): hold txRequest high.
  - ncoEnable falls 20 cycles after rising and wdogTrip=1.
  - No re-key while txRequest stays high.
  - Drop txRequest: wdogTrip clears.
- Reset mid-TX: assert rstN=0 in TX_ACTIVE, between clock edges. All outputs reach their reset values without waiting for a clock edge.
